fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_if.sv | 44 ++++
 rtl/fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_fifo_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: two push requesters, one pop consumer, the external memory
// write/read ports and the status/error flags of the FIFO controller.
interface fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic              pop;
    logic              rd_valid;
    logic [DATA_W-1:0] mem_write_data;
    logic [ADDR_W-1:0] mem_write_addr;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_read_addr;
    logic              mem_read_enable;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] count;
    logic              err_ovf;
    logic              err_udf;
    logic              err_clr;

    // Requester / consumer side
    modport master (
        output req0, data0, req1, data1, pop, err_clr,
        input  gnt0, gnt1, rd_valid,
        input  mem_write_data, mem_write_addr, mem_write_enable,
        input  mem_read_addr, mem_read_enable,
        input  full, empty, count, err_ovf, err_udf
    );

    // Controller side
    modport slave (
        input  req0, data0, req1, data1, pop, err_clr,
        output gnt0, gnt1, rd_valid,
        output mem_write_data, mem_write_addr, mem_write_enable,
        output mem_read_addr, mem_read_enable,
        output full, empty, count, err_ovf, err_udf
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: 8-entry FIFO controller in front of an external dual-port memory.
// Two requesters share the push side through a round-robin arbiter; one
// consumer pops, with read data valid one cycle after an accepted pop.
// Optional sticky overflow/underflow flags are built when the macro
// FIFO_CTRL_ERR_FLAGS_EN is defined; otherwise the flags are tied low.
module fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    fifo_ctrl_if.slave  bus
);
    localparam int IDX_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {LAST_REQ0 = 1'b0, LAST_REQ1 = 1'b1} last_t;

    last_t             last_q;
    last_t             last_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full_p0;
    logic              empty_p0;
    logic [ADDR_W-1:0] count_p0;
    logic              gnt0_p0;
    logic              gnt1_p0;
    logic              push_p0;
    logic              pop_acc_p0;
    logic              vld_p1;

    // Occupancy is derived purely from the pointers; the wrap bit separates
    // full from empty when the index bits match.
    assign empty_p0 = (wr_ptr == rd_ptr);
    assign full_p0  = (wr_ptr[ADDR_W-1] != rd_ptr[ADDR_W-1]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign count_p0 = wr_ptr - rd_ptr;

    // Arbiter: grant a lone requester, alternate on contention, none while full or in reset
    always_comb begin
        gnt0_p0 = 1'b0;
        gnt1_p0 = 1'b0;
        last_d  = last_q;
        if (!rst && !full_p0) begin
            if (bus.req0 && (!bus.req1 || last_q == LAST_REQ1)) begin
                gnt0_p0 = 1'b1;
                last_d  = LAST_REQ0;
            end else if (bus.req1) begin
                gnt1_p0 = 1'b1;
                last_d  = LAST_REQ1;
            end
        end
    end

    assign push_p0    = gnt0_p0 | gnt1_p0;
    assign pop_acc_p0 = !rst && bus.pop && !empty_p0;

    // Last-winner register; reset favours requester 0 on the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= LAST_REQ1;
        end else begin
            last_q <= last_d;
        end
    end

    // Pointers advance on the same edge the memory captures / reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_p0) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc_p0) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ---- stage p0 -> p1: read data from the memory is valid one cycle after the pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pop_acc_p0;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags; a fresh error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if ((bus.req0 || bus.req1) && full_p0) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (bus.pop && empty_p0) begin
                udf_q <= 1'b1;
            end else if (bus.err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign bus.err_ovf = ovf_q;
    assign bus.err_udf = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.err_ovf    = 1'b0;
    assign bus.err_udf    = 1'b0;
`endif

    assign bus.gnt0             = gnt0_p0;
    assign bus.gnt1             = gnt1_p0;
    assign bus.mem_write_enable = push_p0;
    assign bus.mem_write_data   = gnt1_p0 ? bus.data1 : bus.data0;
    assign bus.mem_write_addr   = wr_ptr;
    assign bus.mem_read_enable  = pop_acc_p0;
    assign bus.mem_read_addr    = rd_ptr;
    assign bus.rd_valid         = vld_p1;
    assign bus.full             = full_p0;
    assign bus.empty            = empty_p0;
    assign bus.count            = count_p0;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl. The driver computes the
// expected per-cycle response from a queue-based reference model and pushes
// it; a monitor on the falling edge pops and compares. Popped data is
// checked through an external memory model.
module tb_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External memory clocked by clk, one-cycle read latency
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    always @(posedge clk) begin
        if (bus.mem_write_enable) mem[bus.mem_write_addr[2:0]] <= bus.mem_write_data;
        if (bus.mem_read_enable)  rd_data <= mem[bus.mem_read_addr[2:0]];
    end

    typedef struct {
        int gnt0, gnt1, we, wdata, waddr, re, raddr;
        int full, empty, count, rd_valid, ovf, udf;
    } exp_t;

    exp_t expq[$];
    int   rdq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int mq[$];
    int wp = 0, rp = 0, last = 1, vld = 0, ovf = 0, udf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; expected response computed from the model
    task automatic step(input int r0, input int d0, input int r1, input int d1,
                        input int p, input int clr, input int rs);
        exp_t e;
        int g0, g1, pa, was_full, was_empty;
        @(posedge clk);
        #1;
        rst       = (rs != 0);
        bus.req0  = (r0 != 0);
        bus.data0 = 8'(d0);
        bus.req1  = (r1 != 0);
        bus.data1 = 8'(d1);
        bus.pop   = (p != 0);
        bus.err_clr = (clr != 0);
        if (rs != 0) begin
            mq.delete();
            rdq.delete();
            wp = 0; rp = 0; last = 1; vld = 0; ovf = 0; udf = 0;
        end
        was_full  = (mq.size() == DEPTH) ? 1 : 0;
        was_empty = (mq.size() == 0) ? 1 : 0;
        g0 = 0;
        g1 = 0;
        if (rs == 0 && was_full == 0) begin
            if (r0 != 0 && r1 != 0) begin
                if (last == 1) g0 = 1; else g1 = 1;
            end else begin
                g0 = (r0 != 0) ? 1 : 0;
                g1 = (r1 != 0) ? 1 : 0;
            end
        end
        pa = (rs == 0 && p != 0 && was_empty == 0) ? 1 : 0;
        e.gnt0 = g0;  e.gnt1 = g1;  e.we = g0 | g1;
        e.wdata = (g1 != 0 ? d1 : d0) & 255;
        e.waddr = wp; e.raddr = rp;  e.re = pa;
        e.full = was_full; e.empty = was_empty; e.count = mq.size();
        e.rd_valid = vld; e.ovf = ovf; e.udf = udf;
        expq.push_back(e);
        if (rs == 0) begin
            if (pa != 0) begin
                rdq.push_back(mq.pop_front());
                rp = (rp + 1) % 16;
            end
            if (g0 != 0 || g1 != 0) begin
                mq.push_back(e.wdata);
                wp = (wp + 1) % 16;
                last = g1;
            end
            vld = pa;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
            if ((r0 != 0 || r1 != 0) && was_full != 0) ovf = 1;
            else if (clr != 0) ovf = 0;
            if (p != 0 && was_empty != 0) udf = 1;
            else if (clr != 0) udf = 0;
`endif
        end
    endtask

    // Monitor: compare the cycle's outputs and any returning read data
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("gnt0",     int'(bus.gnt0),             e.gnt0);
                chk("gnt1",     int'(bus.gnt1),             e.gnt1);
                chk("wr_en",    int'(bus.mem_write_enable), e.we);
                if (e.we != 0) chk("wr_data", int'(bus.mem_write_data), e.wdata);
                chk("wr_addr",  int'(bus.mem_write_addr),   e.waddr);
                chk("rd_en",    int'(bus.mem_read_enable),  e.re);
                chk("rd_addr",  int'(bus.mem_read_addr),    e.raddr);
                chk("full",     int'(bus.full),             e.full);
                chk("empty",    int'(bus.empty),            e.empty);
                chk("count",    int'(bus.count),            e.count);
                chk("rd_valid", int'(bus.rd_valid),         e.rd_valid);
                chk("err_ovf",  int'(bus.err_ovf),          e.ovf);
                chk("err_udf",  int'(bus.err_udf),          e.udf);
            end
            if (bus.rd_valid) begin
                if (rdq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data unexpected rd_valid actual=1 required=0 at t=%0t", $time);
                end else begin
                    chk("rd_data", int'(rd_data), rdq.pop_front());
                end
            end
        end
    end

    initial begin
        bus.req0 = 1'b0; bus.data0 = '0; bus.req1 = 1'b0; bus.data1 = '0;
        bus.pop = 1'b0;  bus.err_clr = 1'b0;

        // Single requester after reset
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);
        step(1, 8'hA5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Contention from reset: 0,1,0,1
        repeat (2) step(0, 0, 0, 0, 0, 0, 1);
        repeat (4) step(1, int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 255)), 0, 0, 0);
        // Fill, then overflow attempts (also with a same-cycle pop)
        repeat (4) step(0, 0, 1, int'($urandom_range(0, 255)), 0, 0, 0);
        step(0, 0, 1, 8'h3C, 0, 0, 0);
        step(1, 8'h11, 1, 8'h22, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // Drain, then underflow attempts (also with a same-cycle push)
        repeat (7) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 8'h77, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Steady state at count 3 with push+pop every cycle across the wrap
        repeat (3) step(1, int'($urandom_range(0, 255)), 0, 0, 0, 0, 0);
        repeat (20) step(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                         1, int'($urandom_range(0, 255)), 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset mid-operation, then contended push
        repeat (2) step(0, 0, 1, int'($urandom_range(0, 255)), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 8'hC3, 1, 8'h5A, 0, 0, 0);
        step(1, 8'h0F, 1, 8'hF0, 0, 0, 0);

        // Randomized traffic, alternating push-heavy and pop-heavy phases
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 60; i++) begin
                int push_pct, pop_pct;
                push_pct = (ph % 2 == 0) ? 70 : 25;
                pop_pct  = (ph % 2 == 0) ? 25 : 70;
                step((int'($urandom_range(0, 99)) < push_pct) ? 1 : 0, int'($urandom_range(0, 255)),
                     (int'($urandom_range(0, 99)) < push_pct) ? 1 : 0, int'($urandom_range(0, 255)),
                     (int'($urandom_range(0, 99)) < pop_pct) ? 1 : 0,
                     (int'($urandom_range(0, 99)) < 5) ? 1 : 0,
                     (int'($urandom_range(0, 999)) < 5) ? 1 : 0);
            end
        end

        // Drain outstanding reads
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("expq_drained", expq.size(), 0);
        chk("rdq_drained",  rdq.size(),  0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
